// File: rtl/arb_pkg.sv
// arb_pkg: shared definitions for the four-way round-robin arbiter.
//   NREQ      - number of requesters
//   state_t   - arbiter FSM state (ARB: normal rotation, LOCKED: burst owner)
//   next_idx  - requester index + 1, wrapping mod 4
//   rr_pick   - first requester with req set, searching from start upwards
package arb_pkg;

   localparam int NREQ = 4;

   typedef enum logic {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } state_t;

   function automatic logic [1:0] next_idx(input logic [1:0] idx);
      return idx + 2'd1;
   endfunction

   // The two-bit sum wraps naturally, giving the mod-4 search order.
   function automatic logic [1:0] rr_pick(input logic [NREQ-1:0] req,
                                          input logic [1:0]      start);
      logic [1:0] idx;
      logic       found;
      rr_pick = start;
      found   = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         idx = start + 2'(i);
         if (!found && req[idx]) begin
            rr_pick = idx;
            found   = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/mux4.sv
// mux4: parameterised 4:1 word multiplexer.
//   sel      - select index
//   in0..in3 - N-bit input words
//   y        - selected word
module mux4 #(
   parameter int N = 4
) (
   input  logic [1:0]   sel,
   input  logic [N-1:0] in0,
   input  logic [N-1:0] in1,
   input  logic [N-1:0] in2,
   input  logic [N-1:0] in3,
   output logic [N-1:0] y
);

   // Word selection.
   always_comb begin
      y = in0;
      case (sel)
         2'd0:    y = in0;
         2'd1:    y = in1;
         2'd2:    y = in2;
         2'd3:    y = in3;
         default: y = in0;
      endcase
   end

endmodule

// File: rtl/rr_arb4.sv
// rr_arb4: round-robin arbiter for four requesters sharing one mux4, with
// per-requester burst lock (capped at MAX_BURST grants) and a registered
// valid/ready output stage.
//   clk, rst        - clock, synchronous active-high reset
//   req, lock       - per-requester request and burst-lock
//   in0..in3        - requester words
//   gnt             - one-hot combinational grant (capture cycle)
//   sel             - index of the most recently granted requester (registered)
//   out_valid/data  - registered output word
//   out_ready       - consumer accept
module rr_arb4 #(
   parameter int N         = 4,
   parameter int MAX_BURST = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [3:0]   req,
   input  logic [3:0]   lock,
   input  logic [N-1:0] in0,
   input  logic [N-1:0] in1,
   input  logic [N-1:0] in2,
   input  logic [N-1:0] in3,
   output logic [3:0]   gnt,
   output logic [1:0]   sel,
   output logic         out_valid,
   output logic [N-1:0] out_data,
   input  logic         out_ready
);

   import arb_pkg::*;

   localparam int             BW      = $clog2(MAX_BURST + 1);
   localparam logic [BW-1:0]  MAXB    = BW'(MAX_BURST);
   localparam bit             LOCK_OK = (MAX_BURST > 1);

   state_t        state_r, state_nxt_s;
   logic [1:0]    ptr_r, ptr_nxt_s;
   logic [1:0]    owner_r, owner_nxt_s;
   logic [BW-1:0] bcnt_r, bcnt_nxt_s;

   logic          load_en_s;
   logic          do_arb_s;
   logic          keep_s;
   logic [1:0]    start_s;
   logic [1:0]    win_s;
   logic [N-1:0]  mux_out_s;

   // Winner search and next-state computation for the arbiter FSM.
   always_comb begin
      state_nxt_s = state_r;
      ptr_nxt_s   = ptr_r;
      owner_nxt_s = owner_r;
      bcnt_nxt_s  = bcnt_r;
      keep_s      = 1'b0;
      start_s     = ptr_r;
      load_en_s   = !out_valid || out_ready;
      do_arb_s    = load_en_s && (|req) && !rst;

      // While locked the owner keeps priority until it lets go or hits the
      // burst cap; otherwise the search resumes just past the owner.
      if (state_r == LOCKED) begin
         keep_s  = req[owner_r] && lock[owner_r] && (bcnt_r < MAXB);
         start_s = keep_s ? owner_r : next_idx(owner_r);
      end else begin
         keep_s  = 1'b0;
         start_s = ptr_r;
      end

      win_s = rr_pick(req, start_s);
      gnt   = do_arb_s ? (4'b0001 << win_s) : 4'b0000;

      if (do_arb_s) begin
         if (keep_s) begin
            bcnt_nxt_s = bcnt_r + BW'(1);
         end else if (lock[win_s] && LOCK_OK) begin
            state_nxt_s = LOCKED;
            owner_nxt_s = win_s;
            ptr_nxt_s   = win_s;
            bcnt_nxt_s  = BW'(1);
         end else begin
            state_nxt_s = ARB;
            ptr_nxt_s   = next_idx(win_s);
            bcnt_nxt_s  = '0;
         end
      end else begin
         state_nxt_s = state_r;
      end
   end

   mux4 #(.N(N)) u_mux (
      .sel (win_s),
      .in0 (in0),
      .in1 (in1),
      .in2 (in2),
      .in3 (in3),
      .y   (mux_out_s)
   );

   // Arbiter state and output stage registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ARB;
         ptr_r     <= 2'd0;
         owner_r   <= 2'd0;
         bcnt_r    <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         sel       <= 2'd0;
      end else begin
         state_r <= state_nxt_s;
         ptr_r   <= ptr_nxt_s;
         owner_r <= owner_nxt_s;
         bcnt_r  <= bcnt_nxt_s;
         if (do_arb_s) begin
            out_valid <= 1'b1;
            out_data  <= mux_out_s;
            sel       <= win_s;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rr_arb4.sv
module tb_rr_arb4;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   req;
   logic [3:0]   lock;
   logic [N-1:0] in0, in1, in2, in3;
   logic [3:0]   gnt;
   logic [1:0]   sel;
   logic         out_valid;
   logic [N-1:0] out_data;
   logic         out_ready;

   int n_checks = 0;
   int n_fail   = 0;

   logic [N+1:0] exp_q[$];

   rr_arb4 #(.N(N), .MAX_BURST(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .lock      (lock),
      .in0       (in0),
      .in1       (in1),
      .in2       (in2),
      .in3       (in3),
      .gnt       (gnt),
      .sel       (sel),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Check the combinational grant and queue the word it should deliver.
   task automatic expect_gnt(input logic [3:0] g, input logic [N-1:0] d);
      logic [1:0] idx;
      idx = 2'd0;
      #1;
      chk("gnt", 32'(gnt), 32'(g));
      for (int i = 0; i < 4; i++) begin
         if (g[i]) idx = 2'(i);
      end
      if (g != 4'b0000) exp_q.push_back({idx, d});
   endtask

   // Monitor: every word the consumer accepts is compared with the queue.
   always @(negedge clk) begin
      logic [N+1:0] e;
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_word", 32'({sel, out_data}), 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            chk("word_sel", 32'(sel), 32'(e[N+1:N]));
            chk("word_data", 32'(out_data), 32'(e[N-1:0]));
         end
      end
   end

   initial begin
      rst = 1'b1; req = 4'b0000; lock = 4'b0000; out_ready = 1'b0;
      in0 = 4'd1; in1 = 4'd2; in2 = 4'd3; in3 = 4'd4;
      next_cycle();
      next_cycle();
      // reset state; gnt forced low under reset even with requests
      req = 4'b1111;
      expect_gnt(4'b0000, 4'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      chk("rst_sel", 32'(sel), 32'd0);

      // full rotation, no bubbles
      next_cycle(); rst = 1'b0; out_ready = 1'b1; expect_gnt(4'b0001, 4'd1);
      next_cycle(); chk("no_bubble", 32'(out_valid), 32'd1); expect_gnt(4'b0010, 4'd2);
      next_cycle(); chk("no_bubble", 32'(out_valid), 32'd1); expect_gnt(4'b0100, 4'd3);
      next_cycle(); chk("no_bubble", 32'(out_valid), 32'd1); expect_gnt(4'b1000, 4'd4);
      next_cycle(); chk("no_bubble", 32'(out_valid), 32'd1); expect_gnt(4'b0001, 4'd1);

      // backpressure
      next_cycle(); req = 4'b0110; expect_gnt(4'b0010, 4'd2);
      for (int c = 0; c < 3; c++) begin
         next_cycle(); out_ready = 1'b0; expect_gnt(4'b0000, 4'd0);
         chk("stall_valid", 32'(out_valid), 32'd1);
         chk("stall_data", 32'(out_data), 32'd2);
         chk("stall_sel", 32'(sel), 32'd1);
      end
      next_cycle(); out_ready = 1'b1; expect_gnt(4'b0100, 4'd3);
      next_cycle(); req = 4'b0000; expect_gnt(4'b0000, 4'd0);
      next_cycle(); chk("drain_valid", 32'(out_valid), 32'd0);

      // lock burst capped at four
      req = 4'b0011; lock = 4'b0001;
      expect_gnt(4'b0001, 4'd1);
      next_cycle(); expect_gnt(4'b0001, 4'd1);
      next_cycle(); expect_gnt(4'b0001, 4'd1);
      next_cycle(); expect_gnt(4'b0001, 4'd1);
      next_cycle(); expect_gnt(4'b0010, 4'd2);
      next_cycle(); expect_gnt(4'b0001, 4'd1);

      // early unlock after two grants
      next_cycle(); expect_gnt(4'b0001, 4'd1);
      next_cycle(); lock = 4'b0000; expect_gnt(4'b0010, 4'd2);
      next_cycle(); req = 4'b0101; expect_gnt(4'b0100, 4'd3);

      // idle drain with a single pulse on requester 3
      next_cycle(); req = 4'b1000; expect_gnt(4'b1000, 4'd4);
      next_cycle(); req = 4'b0000; expect_gnt(4'b0000, 4'd0);
      chk("pulse_valid", 32'(out_valid), 32'd1);
      next_cycle(); chk("idle_valid", 32'(out_valid), 32'd0);

      // reset while locked with a pending word
      req = 4'b0100; lock = 4'b0100;
      expect_gnt(4'b0100, 4'd3);
      next_cycle(); rst = 1'b1; out_ready = 1'b0; exp_q.delete();
      expect_gnt(4'b0000, 4'd0);
      next_cycle(); rst = 1'b0; out_ready = 1'b1;
      chk("post_rst_valid", 32'(out_valid), 32'd0);
      req = 4'b0101; lock = 4'b0100;
      expect_gnt(4'b0001, 4'd1);
      next_cycle(); req = 4'b0000; lock = 4'b0000; expect_gnt(4'b0000, 4'd0);
      next_cycle();
      next_cycle();
      chk("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
